byte_write_regfile: RTL

//  Multi-entry register bank with byte-lane write enables. It serves as the TRNG

---
 rtl/byte_write_regfile.sv | 102 ++++++++++
 1 files changed

// File: rtl/byte_write_regfile.sv
// Byte-lane writable register bank with per-entry sticky bus write-lock,
// full-word hardware update port and a registered read port with valid strobe.
module byte_write_regfile #(
    parameter int WIDTH      = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH),
    parameter int WE_WIDTH   = (WIDTH - 1) / BYTE_WIDTH + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WE_WIDTH-1:0] wr_be,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                hw_we,
    input  logic [AW-1:0]       hw_addr,
    input  logic [WIDTH-1:0]    hw_data,
    input  logic                lock_en,
    input  logic [AW-1:0]       lock_addr,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_valid,
    output logic                rd_err,
    output logic                wr_err,
    output logic [DEPTH-1:0]    lock_o
);

    logic [WIDTH-1:0] mem      [DEPTH];
    logic [WIDTH-1:0] next_mem [DEPTH];
    logic [WIDTH-1:0] lane_mask;
    logic [DEPTH-1:0] wr_sel;
    logic [DEPTH-1:0] hw_sel;
    logic [DEPTH-1:0] lock_sel;
    logic [DEPTH-1:0] rd_sel;
    logic             wr_hit;
    logic             wr_ok;
    logic             rd_in_range;

    // The top lane naturally ends up narrower when WIDTH is not a multiple of BYTE_WIDTH.
    for (genvar b = 0; b < WIDTH; b++) begin : g_mask
        assign lane_mask[b] = wr_be[b / BYTE_WIDTH];
    end

    always_comb begin
        wr_sel   = '0;
        hw_sel   = '0;
        lock_sel = '0;
        rd_sel   = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wr_sel[e]   = (wr_addr   == AW'(e));
            hw_sel[e]   = (hw_addr   == AW'(e));
            lock_sel[e] = (lock_addr == AW'(e));
            rd_sel[e]   = (rd_addr   == AW'(e));
        end
    end

    // Out-of-range addresses decode to no entry, so they fall out as rejected/ignored.
    assign wr_hit      = wr_en && (wr_be != '0);
    assign wr_ok       = wr_hit && (|(wr_sel & ~lock_o));
    assign rd_in_range = |rd_sel;

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            next_mem[e] = mem[e];
            if (hw_we && hw_sel[e]) begin
                next_mem[e] = hw_data;
            end
            if (wr_ok && wr_sel[e]) begin
                next_mem[e] = (next_mem[e] & ~lane_mask) | (wr_data & lane_mask);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
            lock_o   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= next_mem[e];
            end
            if (lock_en) begin
                lock_o <= lock_o | lock_sel;
            end
            wr_err   <= wr_hit && !wr_ok;
            rd_valid <= rd_en;
            rd_err   <= rd_en && !rd_in_range;
            if (rd_en) begin
                rd_data <= rd_in_range ? mem[rd_addr] : '0;
            end
        end
    end

endmodule
